// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter/holding-register signals of the UART TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_REQ     = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
    logic                           tx_done;
    logic                           flush;
    logic [NUM_REQ-1:0]             grant;
    logic [ID_W-1:0]                grant_id;
    logic                           reg_enable;
    logic                           reg_sync_reset;
    logic [WORD_LENGTH-1:0]         reg_data;
    logic                           tx_start;
    logic                           busy;
    logic                           timeout_err;
    modport slave (
        input  req, req_data, tx_done, flush,
        output grant, grant_id, reg_enable, reg_sync_reset, reg_data, tx_start, busy, timeout_err
    );
    modport master (
        output req, req_data, tx_done, flush,
        input  grant, grant_id, reg_enable, reg_sync_reset, reg_data, tx_start, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter and its holding register,
// with a saturating watchdog that forces recovery when tx_done never arrives.
module uart_tx_arbiter #(
    parameter int WORD_LENGTH    = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CLEAR} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_grant_id;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_idx;

    // Scan from ptr+NUM_REQ down to ptr+1 so the nearest set bit after ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.flush) begin
                        r_state <= S_CLEAR;
                    end else if (w_found) begin
                        r_state    <= S_LOAD;
                        r_grant_id <= w_win;
                        r_ptr      <= w_win;
                    end
                end
                S_LOAD:  r_state <= bus.flush ? S_CLEAR : S_START;
                S_START: begin
                    r_state <= bus.flush ? S_CLEAR : S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
                    if (bus.flush || bus.tx_done) begin
                        r_state <= S_CLEAR;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= S_CLEAR;
                        r_err   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant          = (r_state == S_LOAD) ? NUM_REQ'(1) << r_grant_id : '0;
    assign bus.grant_id       = r_grant_id;
    assign bus.reg_enable     = (r_state == S_LOAD) || (r_state == S_CLEAR);
    assign bus.reg_sync_reset = (r_state == S_CLEAR);
    assign bus.reg_data       = (r_state == S_LOAD) ? bus.req_data[int'(r_grant_id)*WORD_LENGTH +: WORD_LENGTH] : '0;
    assign bus.tx_start       = (r_state == S_START);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.timeout_err    = (r_state == S_CLEAR) && r_err;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one UART transmitter and its 16-bit holding register (PIPO with enable and synchronous clear) among several requesters. It grants one requester at a time, loads that requester's word into the holding register, starts the transmitter, and waits for completion. It then clears the holding register and moves on to the next requester. A watchdog recovers the block if the transmitter never reports done.

## Interface
- WORD_LENGTH, 16, width of each requester word and of the holding register
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT before forced recovery
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held until granted
- req_data  in  NUM_REQ*WORD_LENGTH  requester words, slice i = bits [i*WORD_LENGTH +: WORD_LENGTH]; stable while req[i]=1
- tx_done  in  1  one-cycle pulse from transmitter: frame finished
- flush  in  1  synchronous abort: clear holding register, return to IDLE
- grant  out  NUM_REQ  one-hot, one-cycle acknowledge to the winner
- grant_id  out  $clog2(NUM_REQ)  index of current/last winner
- reg_enable  out  1  holding-register enable
- reg_sync_reset  out  1  holding-register synchronous clear
- reg_data  out  WORD_LENGTH  holding-register data input
- tx_start  out  1  one-cycle start pulse to transmitter
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, LOAD, START, WAIT, CLEAR. All outputs are decoded from the registered state and grant_id.
- IDLE: if flush=1, go to CLEAR. Otherwise, if any req bit is set, select the winner and go to LOAD.
- Winner selection: the first set req bit, searching from ptr+1 upward and wrapping modulo NUM_REQ. The winner is latched into grant_id, and ptr takes the winner's value.
- LOAD: grant[grant_id]=1, reg_enable=1, reg_sync_reset=0, reg_data=req_data slice[grant_id]. Always go to START.
- START: tx_start=1. Go to WAIT, and clear the watchdog counter.
- WAIT: the counter increments every cycle.
  - If tx_done=1, go to CLEAR.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to CLEAR and set the error flag.
- CLEAR: reg_enable=1, reg_sync_reset=1, and timeout_err=1 if the error flag is set. Always go to IDLE; the error flag clears.
- reg_data is 0 in every state except LOAD. grant is 0 in every state except LOAD.
- flush=1 in LOAD, START or WAIT forces the next state to CLEAR, with no timeout_err. flush in CLEAR is ignored.
- tx_done outside WAIT is ignored.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Reset values: state=IDLE, ptr=NUM_REQ-1 (so requester 0 has first priority), grant_id=0, counter=0, error flag=0. All outputs are 0.
- Reset asserted mid-operation aborts immediately. The transmitter and holding register are reset by the same signal, so no CLEAR is needed.

## Timing
- Request to grant:
  - req[i] is sampled at edge E0 in IDLE.
  - grant[i], reg_enable and reg_data are valid in the cycle after E0.
  - The holding register captures the word at E1.
  - tx_start is high in the cycle after E1.
- Completion to next grant:
  - tx_done is sampled at edge En; CLEAR is active in the cycle after En.
  - IDLE follows at En+1.
  - The earliest next grant is in the cycle after En+2.
- Minimum overhead per word: 4 cycles plus transmitter time (LOAD, START, CLEAR, IDLE).
- A requester must deassert req, or present its next word, on the edge at which grant is high. If req stays high, it re-competes next round at lowest priority.
- Simultaneous tx_done and counter==TIMEOUT_CYCLES-1: tx_done wins and no timeout_err is raised.
- Simultaneous flush and tx_done in WAIT: go to CLEAR with no timeout_err. The result is identical either way.

## Test plan
- Single request: req=4'b0001, req_data[0]=16'hA5C3.
  - Expect grant=0001 and reg_data=A5C3 one cycle after the sampling edge, then tx_start the next cycle.
  - tx_done 10 cycles later → CLEAR pulse (reg_enable=reg_sync_reset=1), then busy=0.
- Round-robin fairness: req=4'b1111 held continuously, tx_done 3 cycles after each tx_start.
  - Expect grant_id sequence 0,1,2,3,0,1.
  - Expect exactly 4 idle-to-grant overhead cycles between consecutive tx_start pulses plus the transmit time.
- Wrap-around: after requester 3 is served, req=4'b1001.
  - Expect requester 0 next, then requester 3.
- Watchdog: TIMEOUT_CYCLES=16, no tx_done after tx_start.
  - Expect CLEAR exactly 16 cycles after entering WAIT, timeout_err=1 for one cycle, then IDLE.
  - The next request is still granted normally.
- Flush in WAIT: flush asserted 2 cycles after tx_start.
  - Expect CLEAR next cycle, no timeout_err, IDLE after.
  - A late tx_done in IDLE is ignored.
- Async reset: drive reset low during START.
  - All outputs go to 0 immediately and state returns to IDLE.
  - With req=4'b0110 after release, requester 1 is granted first.
